// File: rtl/scan_coord_gen.sv
// scan_coord_gen: raster scan coordinate source.
// Walks a WIDTH x HEIGHT frame in row-major order and emits one complex-plane
// sample point (x, y) per pixel over a valid/ready handshake. The real axis
// grows to the right and the imaginary axis grows upward, so y decreases line
// by line. Origin and step are captured into shadow registers only when a
// frame starts, which keeps a frame internally consistent even if the
// configuration inputs move while it is being scanned.
module scan_coord_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [CW-1:0] cfg_origin_re,
    input  logic signed [CW-1:0] cfg_origin_im,
    input  logic        [CW-1:0] cfg_step,
    input  logic                 ready,
    output logic signed [CW-1:0] x,
    output logic signed [CW-1:0] y,
    output logic                 first,
    output logic                 lastx,
    output logic                 lasty,
    output logic                 valid
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic signed [CW-1:0] sh_origin_re;
    logic signed [CW-1:0] sh_origin_im;
    logic        [CW-1:0] sh_step;

    logic col_at_end;
    logic row_at_end;
    logic xfer;
    logic end_frame;
    logic load_frame;
    logic advance;
    logic go_idle;

    assign col_at_end = (col == COL_LAST);
    assign row_at_end = (row == ROW_LAST);

    // State register: frame-level sequencing between waiting and scanning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a frame ends only when its last pixel is accepted;
    // dropping enable earlier just lets the current frame run to completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (end_frame && !enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control strobes: decide which datapath update happens this cycle.
    // A new frame loads either from IDLE or directly after the final pixel
    // of the previous frame, giving back-to-back frames with no bubble.
    always_comb begin
        xfer       = 1'b0;
        end_frame  = 1'b0;
        load_frame = 1'b0;
        advance    = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: begin
                load_frame = enable;
            end
            RUN: begin
                xfer       = valid & ready;
                end_frame  = xfer & col_at_end & row_at_end;
                load_frame = end_frame & enable;
                go_idle    = end_frame & ~enable;
                advance    = xfer & ~end_frame;
            end
            default: begin
                load_frame = 1'b0;
            end
        endcase
    end

    // Datapath: counters, shadow configuration and the registered beat.
    // Nothing changes while a beat is stalled, so the beat holds steady.
    // Adds and subtracts wrap modulo 2^CW; the step is treated as unsigned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            sh_origin_re <= '0;
            sh_origin_im <= '0;
            sh_step      <= '0;
            x            <= '0;
            y            <= '0;
            first        <= 1'b0;
            lastx        <= 1'b0;
            lasty        <= 1'b0;
            valid        <= 1'b0;
        end else if (load_frame) begin
            sh_origin_re <= cfg_origin_re;
            sh_origin_im <= cfg_origin_im;
            sh_step      <= cfg_step;
            x            <= cfg_origin_re;
            y            <= cfg_origin_im;
            col          <= '0;
            row          <= '0;
            first        <= 1'b1;
            lastx        <= 1'b0;
            lasty        <= 1'b0;
            valid        <= 1'b1;
        end else if (go_idle) begin
            col   <= '0;
            row   <= '0;
            x     <= sh_origin_re;
            y     <= sh_origin_im;
            first <= 1'b0;
            lastx <= 1'b0;
            lasty <= 1'b0;
            valid <= 1'b0;
        end else if (advance) begin
            first <= 1'b0;
            if (!col_at_end) begin
                col   <= col + 1'b1;
                x     <= x + $signed(sh_step);
                lastx <= (col == COL_LAST - 1'b1);
            end else begin
                col   <= '0;
                x     <= sh_origin_re;
                lastx <= 1'b0;
                row   <= row + 1'b1;
                y     <= y - $signed(sh_step);
                lasty <= (row == ROW_LAST - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_scan_coord_gen.sv
// tb_scan_coord_gen: directed bench for scan_coord_gen on a 4 x 3 raster.
// Inputs change and outputs are sampled on the falling clock edge, so every
// check sees the beat registered at the preceding rising edge.
module tb_scan_coord_gen;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int CW     = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 ready = 1'b0;
    logic signed [CW-1:0] cfg_origin_re = '0;
    logic signed [CW-1:0] cfg_origin_im = '0;
    logic        [CW-1:0] cfg_step = '0;
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic                 first;
    logic                 lastx;
    logic                 lasty;
    logic                 valid;

    int cmp_count = 0;
    int err_count = 0;

    // Hand-computed beats of a frame with origin (-100, 50), step 10,
    // followed by the first beat of the next frame. Flags are {first,lastx,lasty}.
    int bx[13] = '{-100, -90, -80, -70, -100, -90, -80, -70, -100, -90, -80, -70, -100};
    int by[13] = '{50, 50, 50, 50, 40, 40, 40, 40, 30, 30, 30, 30, 50};
    logic [2:0] bf[13] = '{3'b100, 3'b000, 3'b000, 3'b010,
                           3'b000, 3'b000, 3'b000, 3'b010,
                           3'b001, 3'b001, 3'b001, 3'b011,
                           3'b100};

    logic [3*CW/CW+CW*2:0] dummy_unused;

    scan_coord_gen #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .CW    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_origin_re(cfg_origin_re),
        .cfg_origin_im(cfg_origin_im),
        .cfg_step     (cfg_step),
        .ready        (ready),
        .x            (x),
        .y            (y),
        .first        (first),
        .lastx        (lastx),
        .lasty        (lasty),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    // Observed beat packed as {valid, first, lastx, lasty, x, y}.
    function automatic logic [2*CW+3:0] observed();
        return {valid, first, lastx, lasty, x, y};
    endfunction

    // Expected beat for index b of the reference frame table.
    function automatic logic [2*CW+3:0] table_beat(input int b);
        return {1'b1, bf[b], CW'(bx[b]), CW'(by[b])};
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        ready  = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Loads configuration, raises enable and waits (bounded) for the first beat.
    task automatic start_frame(input int ore, input int oim, input int st, output bit ok);
        cfg_origin_re = CW'(ore);
        cfg_origin_im = CW'(oim);
        cfg_step      = CW'(st);
        enable        = 1'b1;
        ready         = 1'b1;
        ok            = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        cmp_count++;
        if (observed() !== '0) begin
            err_count++;
            $display("[TB] FAIL reset_state: got %h, want %h", observed(), 36'h0);
        end
    endtask

    task automatic test_idle();
        enable = 1'b0;
        ready  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ready = ~ready;
            cmp_count++;
            if (valid !== 1'b0) begin
                err_count++;
                $display("[TB] FAIL idle_valid cycle %0d: got %b, want 0", i, valid);
            end
        end
    endtask

    task automatic test_basic_scan();
        bit ok;
        do_reset();
        start_frame(-100, 50, 10, ok);
        cmp_count++;
        if (ok !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL basic_start: valid got 0, want 1");
        end
        for (int b = 0; b < 13; b++) begin
            cmp_count++;
            if (observed() !== table_beat(b)) begin
                err_count++;
                $display("[TB] FAIL basic_beat%0d: got %h, want %h", b, observed(), table_beat(b));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        start_frame(-100, 50, 10, ok);
        cmp_count++;
        if (ok !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL bp_start: valid got 0, want 1");
        end
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmp_count++;
            if (observed() !== table_beat(2)) begin
                err_count++;
                $display("[TB] FAIL bp_hold%0d: got %h, want %h", i, observed(), table_beat(2));
            end
            @(negedge clk);
        end
        ready = 1'b1;
        cmp_count++;
        if (observed() !== table_beat(2)) begin
            err_count++;
            $display("[TB] FAIL bp_hold_last: got %h, want %h", observed(), table_beat(2));
        end
        @(negedge clk);
        cmp_count++;
        if (observed() !== table_beat(3)) begin
            err_count++;
            $display("[TB] FAIL bp_resume: got %h, want %h", observed(), table_beat(3));
        end
    endtask

    task automatic test_mid_frame_cfg();
        bit ok;
        logic [2*CW+3:0] want;
        do_reset();
        start_frame(-100, 50, 10, ok);
        cmp_count++;
        if (ok !== 1'b1) begin
            err_count++;
            $display("[TB] FAIL mid_start: valid got 0, want 1");
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
        cfg_origin_re = '0;
        cfg_origin_im = '0;
        enable        = 1'b0;
        for (int b = 5; b < 12; b++) begin
            cmp_count++;
            if (observed() !== table_beat(b)) begin
                err_count++;
                $display("[TB] FAIL mid_beat%0d: got %h, want %h", b, observed(), table_beat(b));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            cmp_count++;
            if (valid !== 1'b0) begin
                err_count++;
                $display("[TB] FAIL mid_stopped%0d: valid got %b, want 0", i, valid);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        want = {1'b1, 3'b100, CW'(0), CW'(0)};
        cmp_count++;
        if (observed() !== want) begin
            err_count++;
            $display("[TB] FAIL mid_restart: got %h, want %h", observed(), want);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        start_frame(32760, 0, 10, ok);
        cmp_count++;
        if (ok !== 1'b1 || x !== 16'sd32760) begin
            err_count++;
            $display("[TB] FAIL wrap_beat0: x got %0d, want 32760", x);
        end
        @(negedge clk);
        cmp_count++;
        if (x !== -16'sd32766) begin
            err_count++;
            $display("[TB] FAIL wrap_beat1: x got %0d, want -32766", x);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [2*CW+3:0] want;
        do_reset();
        start_frame(-100, 50, 10, ok);
        for (int i = 0; i < 6; i++) @(negedge clk);
        cmp_count++;
        if (ok !== 1'b1 || observed() !== table_beat(6)) begin
            err_count++;
            $display("[TB] FAIL arst_beat6: got %h, want %h", observed(), table_beat(6));
        end
        #2 reset = 1'b1;
        #1;
        cmp_count++;
        if (observed() !== '0) begin
            err_count++;
            $display("[TB] FAIL arst_immediate: got %h, want %h", observed(), 36'h0);
        end
        cfg_origin_re = 16'sd20;
        cfg_origin_im = 16'sd30;
        enable        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        want = {1'b1, 3'b100, CW'(20), CW'(30)};
        cmp_count++;
        if (ok !== 1'b1 || observed() !== want) begin
            err_count++;
            $display("[TB] FAIL arst_restart: got %h, want %h", observed(), want);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic_scan();
        test_backpressure();
        test_mid_frame_cfg();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
